// File: rtl/dram_pkg.sv
// Shared constants for the DRAM key/value table: line geometry, FIFO word layout and
// the update-writer FSM state encoding.
package dram_pkg;

    localparam int unsigned DRAM_LINE_LOG2  = 5;
    localparam int unsigned DRAM_LINE_BYTES = 32;
    localparam int unsigned LINE_W          = 256;
    localparam int unsigned KV_FIELD_W      = 32;
    localparam int unsigned KV_KEY_LSB      = 0;
    localparam int unsigned KV_VAL_LSB      = 32;
    localparam int unsigned STAT_W          = 32;

    // Update FIFO word: {key[63:32], value[31:0]}
    localparam int unsigned FIFO_W       = 64;
    localparam int unsigned FIFO_KEY_LSB = 32;
    localparam int unsigned FIFO_KEY_MSB = 63;
    localparam int unsigned FIFO_VAL_LSB = 0;
    localparam int unsigned FIFO_VAL_MSB = 31;

    localparam int unsigned NUM_STATES        = 6;
    localparam int unsigned ST_IDLE_BIT       = 0;
    localparam int unsigned ST_POP_BIT        = 1;
    localparam int unsigned ST_LATCH_BIT      = 2;
    localparam int unsigned ST_GO_BIT         = 3;
    localparam int unsigned ST_PUSH_BIT       = 4;
    localparam int unsigned ST_WAIT_DONE_BIT  = 5;

    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE      = NUM_STATES'(1 << ST_IDLE_BIT),
        ST_POP       = NUM_STATES'(1 << ST_POP_BIT),
        ST_LATCH     = NUM_STATES'(1 << ST_LATCH_BIT),
        ST_GO        = NUM_STATES'(1 << ST_GO_BIT),
        ST_PUSH      = NUM_STATES'(1 << ST_PUSH_BIT),
        ST_WAIT_DONE = NUM_STATES'(1 << ST_WAIT_DONE_BIT)
    } upd_state_e;

    // DDR line payload as the reader expects it; upper bits are padding.
    typedef struct packed {
        logic [LINE_W-2*KV_FIELD_W-1:0] pad;
        logic [KV_FIELD_W-1:0]          value;
        logic [KV_FIELD_W-1:0]          key;
    } kv_line_t;

    function automatic kv_line_t kv_line(input logic [KV_FIELD_W-1:0] key,
                                         input logic [KV_FIELD_W-1:0] value);
        kv_line_t line;
        line       = '0;
        line.key   = key;
        line.value = value;
        return line;
    endfunction

endpackage

// File: rtl/dram_update_write_if.sv
// Update FIFO read port plus Avalon write-master control/buffer port of the update writer.
interface dram_update_write_if #(
    parameter int unsigned AW = 31
);
    import dram_pkg::*;

    logic [FIFO_W-1:0] upd_fifo_readdata;
    logic              upd_fifo_read;
    logic              upd_fifo_empty;
    logic              control_fixed_location;
    logic [AW-1:0]     control_write_base;
    logic [AW-1:0]     control_write_length;
    logic              control_go;
    logic              control_done;
    logic              user_write_buffer;
    logic [LINE_W-1:0] user_buffer_input_data;
    logic              user_buffer_full;

    modport master (
        input  upd_fifo_readdata,
        output upd_fifo_read,
        input  upd_fifo_empty,
        output control_fixed_location,
        output control_write_base,
        output control_write_length,
        output control_go,
        input  control_done,
        output user_write_buffer,
        output user_buffer_input_data,
        input  user_buffer_full
    );

    modport slave (
        output upd_fifo_readdata,
        input  upd_fifo_read,
        output upd_fifo_empty,
        input  control_fixed_location,
        input  control_write_base,
        input  control_write_length,
        input  control_go,
        output control_done,
        input  user_write_buffer,
        input  user_buffer_input_data,
        output user_buffer_full
    );

endinterface

// File: rtl/dram_wr_stats.sv
// Write/drop statistics counters for the update writer; wrap modulo 2^32, cleared by reset only.
module dram_wr_stats
    import dram_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_inc,
    input  logic              i_drop_inc,
    output logic [STAT_W-1:0] o_wr_count,
    output logic [STAT_W-1:0] o_drop_count
);

    logic [STAT_W-1:0] r_wr_count;
    logic [STAT_W-1:0] r_drop_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (i_wr_inc)   r_wr_count   <= r_wr_count + STAT_W'(1);
            if (i_drop_inc) r_drop_count <= r_drop_count + STAT_W'(1);
        end
    end

    assign o_wr_count   = r_wr_count;
    assign o_drop_count = r_drop_count;

endmodule

// File: rtl/dram_update_write.sv
// Drains {key,value} updates into key-indexed 32-byte DDR lines, then hands off with dram_flush.
// Optional statistics counters are built when DRAM_WR_STATS_EN is defined.
module dram_update_write
    import dram_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 31,
    parameter logic [ADDRESS_WIDTH-1:0] DDR_BASE      = '0,
    parameter int unsigned              MAX_KEYS      = 1024
)(
    input  logic                    clk,
    input  logic                    reset_n,
    dram_update_write_if.master     bus,
    input  logic                    flush_req,
    input  logic [STAT_W-1:0]       num_keys,
    output logic                    dram_flush,
    output logic                    busy,
    output logic [STAT_W-1:0]       wr_count,
    output logic [STAT_W-1:0]       drop_count
);

    upd_state_e               r_state;
    upd_state_e               w_state_nxt;

    logic                     r_fifo_read;
    logic                     r_go;
    logic                     r_write_buffer;
    logic                     r_dram_flush;
    logic                     r_busy;
    logic                     r_flush_pending;
    logic [ADDRESS_WIDTH-1:0] r_base;
    logic [LINE_W-1:0]        r_data;

    logic                     w_fifo_read_nxt;
    logic                     w_go_nxt;
    logic                     w_write_buffer_nxt;
    logic                     w_dram_flush_nxt;
    logic                     w_busy_nxt;
    logic                     w_pending_clr;
    logic                     w_pending_nxt;
    logic [ADDRESS_WIDTH-1:0] w_base_nxt;
    logic [LINE_W-1:0]        w_data_nxt;
    logic                     w_wr_inc;
    logic                     w_drop_inc;

    logic [KV_FIELD_W-1:0]    w_key;
    logic [KV_FIELD_W-1:0]    w_value;
    logic                     w_drop;

    assign w_key   = bus.upd_fifo_readdata[FIFO_KEY_MSB:FIFO_KEY_LSB];
    assign w_value = bus.upd_fifo_readdata[FIFO_VAL_MSB:FIFO_VAL_LSB];

    // Out-of-range keys are dropped rather than allowed to alias another line.
    assign w_drop  = (w_key >= num_keys) || (w_key >= STAT_W'(MAX_KEYS));

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt        = r_state;
        w_fifo_read_nxt    = 1'b0;
        w_go_nxt           = 1'b0;
        w_write_buffer_nxt = 1'b0;
        w_dram_flush_nxt   = 1'b0;
        w_pending_clr      = 1'b0;
        w_base_nxt         = r_base;
        w_data_nxt         = r_data;
        w_wr_inc           = 1'b0;
        w_drop_inc         = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (!bus.upd_fifo_empty) begin
                    w_fifo_read_nxt = 1'b1;
                    w_state_nxt     = ST_POP;
                end else if (r_flush_pending) begin
                    w_dram_flush_nxt = 1'b1;
                    w_pending_clr    = 1'b1;
                end
            end
            ST_POP: begin
                w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                if (w_drop) begin
                    w_drop_inc  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_base_nxt  = DDR_BASE + ADDRESS_WIDTH'({w_key, DRAM_LINE_LOG2'(0)});
                    w_data_nxt  = kv_line(w_key, w_value);
                    w_go_nxt    = 1'b1;
                    w_state_nxt = ST_GO;
                end
            end
            ST_GO: begin
                w_state_nxt = ST_PUSH;
            end
            ST_PUSH: begin
                if (!bus.user_buffer_full) begin
                    w_write_buffer_nxt = 1'b1;
                    w_state_nxt        = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.control_done) begin
                    w_wr_inc    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A request arriving in the issue cycle survives and earns its own pulse.
        w_pending_nxt = (r_flush_pending && !w_pending_clr) || flush_req;
        w_busy_nxt    = (w_state_nxt != ST_IDLE) || w_pending_nxt;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_fifo_read     <= 1'b0;
            r_go            <= 1'b0;
            r_write_buffer  <= 1'b0;
            r_dram_flush    <= 1'b0;
            r_busy          <= 1'b0;
            r_flush_pending <= 1'b0;
            r_base          <= '0;
            r_data          <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_fifo_read     <= w_fifo_read_nxt;
            r_go            <= w_go_nxt;
            r_write_buffer  <= w_write_buffer_nxt;
            r_dram_flush    <= w_dram_flush_nxt;
            r_busy          <= w_busy_nxt;
            r_flush_pending <= w_pending_nxt;
            r_base          <= w_base_nxt;
            r_data          <= w_data_nxt;
        end
    end

    assign bus.upd_fifo_read          = r_fifo_read;
    assign bus.control_fixed_location = 1'b0;
    assign bus.control_write_base     = r_base;
    assign bus.control_write_length   = ADDRESS_WIDTH'(DRAM_LINE_BYTES);
    assign bus.control_go             = r_go;
    assign bus.user_write_buffer      = r_write_buffer;
    assign bus.user_buffer_input_data = r_data;
    assign dram_flush                 = r_dram_flush;
    assign busy                       = r_busy;

`ifdef DRAM_WR_STATS_EN
    dram_wr_stats u_stats (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_wr_inc     (w_wr_inc),
        .i_drop_inc   (w_drop_inc),
        .o_wr_count   (wr_count),
        .o_drop_count (drop_count)
    );
`else
    logic w_unused_stats;
    assign w_unused_stats = w_wr_inc | w_drop_inc;
    assign wr_count       = '0;
    assign drop_count     = '0;
`endif

endmodule

// File: tb/tb_dram_update_write.sv
// Directed bench for dram_update_write: update FIFO model, Avalon write-master model, vector table.
module tb_dram_update_write;
    import dram_pkg::*;

    localparam int unsigned AW = 31;
`ifdef DRAM_WR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush_req = 1'b0;
    logic [31:0] num_keys = 32'd8;
    logic        dram_flush;
    logic        busy;
    logic [31:0] wr_count;
    logic [31:0] drop_count;

    always #5 clk = ~clk;

    dram_update_write_if #(.AW(AW)) bus ();

    dram_update_write #(
        .ADDRESS_WIDTH (AW),
        .DDR_BASE      ('0),
        .MAX_KEYS      (1024)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .flush_req  (flush_req),
        .num_keys   (num_keys),
        .dram_flush (dram_flush),
        .busy       (busy),
        .wr_count   (wr_count),
        .drop_count (drop_count)
    );

    // Update FIFO: q valid the cycle after the read strobe
    logic [63:0] fifo_mem [0:63];
    logic [5:0]  fifo_wp = '0;
    logic [5:0]  fifo_rp = '0;
    assign bus.upd_fifo_empty = (fifo_wp == fifo_rp);

    always @(posedge clk) begin
        if (bus.upd_fifo_read && (fifo_wp != fifo_rp)) begin
            bus.upd_fifo_readdata <= fifo_mem[fifo_rp];
            fifo_rp <= fifo_rp + 6'd1;
        end
    end

    // Write master: done drops at go, rises 3 cycles after the buffer push
    logic           m_done = 1'b1;
    int             m_cnt = 0;
    int             go_n = 0, push_n = 0, flush_n = 0, done_n = 0, flush_at_done = -1;
    logic [AW-1:0]  base_log [0:63];
    logic [255:0]   last_data = '0;
    logic           buf_full = 1'b0;
    assign bus.control_done     = m_done;
    assign bus.user_buffer_full = buf_full;

    always @(posedge clk) begin
        if (!reset_n) begin
            m_done <= 1'b1;
            m_cnt  <= 0;
        end else begin
            if (bus.control_go) begin
                base_log[go_n[5:0]] <= bus.control_write_base;
                go_n   <= go_n + 1;
                m_done <= 1'b0;
            end
            if (bus.user_write_buffer) begin
                last_data <= bus.user_buffer_input_data;
                push_n    <= push_n + 1;
                m_cnt     <= 3;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    done_n <= done_n + 1;
                end
            end
        end
        if (dram_flush) begin
            flush_n       <= flush_n + 1;
            flush_at_done <= done_n;
        end
    end

    int checks = 0;
    int failures = 0;
    int exp_wr = 0;
    int exp_drop = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_upd(input logic [31:0] key, input logic [31:0] value);
        fifo_mem[fifo_wp] = {key, value};
        fifo_wp = fifo_wp + 6'd1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while ((busy || !bus.upd_fifo_empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 256'(n < budget), 256'(1));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_wr_count"},   256'(wr_count),   STATS ? 256'(exp_wr)   : 256'(0));
        chk({tag, "_drop_count"}, 256'(drop_count), STATS ? 256'(exp_drop) : 256'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   256'(busy),                        256'(0));
        chk({tag, "_flush"},  256'(dram_flush),                  256'(0));
        chk({tag, "_read"},   256'(bus.upd_fifo_read),           256'(0));
        chk({tag, "_go"},     256'(bus.control_go),              256'(0));
        chk({tag, "_wbuf"},   256'(bus.user_write_buffer),       256'(0));
        chk({tag, "_base"},   256'(bus.control_write_base),      256'(0));
        chk({tag, "_len"},    256'(bus.control_write_length),    256'(32));
        chk({tag, "_fixed"},  256'(bus.control_fixed_location),  256'(0));
        chk({tag, "_data"},   bus.user_buffer_input_data,        256'(0));
        chk({tag, "_wrcnt"},  256'(wr_count),                    256'(0));
        chk({tag, "_dropcnt"},256'(drop_count),                  256'(0));
    endtask

    typedef struct {
        logic [31:0]   key;
        logic [31:0]   value;
        logic [31:0]   nk;
        logic          drop;
        logic [AW-1:0] base;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int g0, p0, f0, d0;
        logic seen, bad;

        vecs[0] = '{key: 32'd3,          value: 32'hDEADBEEF, nk: 32'd8,          drop: 1'b0, base: 31'h60};
        vecs[1] = '{key: 32'd8,          value: 32'h11111111, nk: 32'd8,          drop: 1'b1, base: 31'h0};
        vecs[2] = '{key: 32'd7,          value: 32'hCAFEF00D, nk: 32'd8,          drop: 1'b0, base: 31'hE0};
        vecs[3] = '{key: 32'd0,          value: 32'h00000001, nk: 32'd1,          drop: 1'b0, base: 31'h0};
        vecs[4] = '{key: 32'd1,          value: 32'h22222222, nk: 32'd1,          drop: 1'b1, base: 31'h0};
        vecs[5] = '{key: 32'd1023,       value: 32'hA5A5A5A5, nk: 32'd2000,       drop: 1'b0, base: 31'h7FE0};
        vecs[6] = '{key: 32'd1024,       value: 32'h33333333, nk: 32'd2000,       drop: 1'b1, base: 31'h0};
        vecs[7] = '{key: 32'hFFFFFFFF,   value: 32'h44444444, nk: 32'hFFFFFFFF,   drop: 1'b1, base: 31'h0};
        vecs[8] = '{key: 32'd5,          value: 32'h55555555, nk: 32'd0,          drop: 1'b1, base: 31'h0};

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table: one update each, writes versus drops
        for (int i = 0; i < 9; i++) begin
            num_keys = vecs[i].nk;
            g0 = go_n;
            p0 = push_n;
            push_upd(vecs[i].key, vecs[i].value);
            wait_idle(100);
            if (vecs[i].drop) begin
                exp_drop++;
                chk($sformatf("vec%0d_go", i),   256'(go_n - g0),   256'(0));
                chk($sformatf("vec%0d_push", i), 256'(push_n - p0), 256'(0));
            end else begin
                exp_wr++;
                chk($sformatf("vec%0d_go", i),   256'(go_n - g0),   256'(1));
                chk($sformatf("vec%0d_push", i), 256'(push_n - p0), 256'(1));
                chk($sformatf("vec%0d_base", i), 256'(base_log[g0[5:0]]), 256'(vecs[i].base));
                chk($sformatf("vec%0d_data", i), last_data, {192'b0, vecs[i].value, vecs[i].key});
            end
            chk_counters($sformatf("vec%0d", i));
        end

        // Three queued updates with a flush request right behind them
        num_keys = 32'd8;
        g0 = go_n; f0 = flush_n; d0 = done_n;
        push_upd(32'd0, 32'h100);
        push_upd(32'd1, 32'h101);
        push_upd(32'd2, 32'h102);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        wait_idle(300);
        exp_wr += 3;
        chk("fl3_go",    256'(go_n - g0),             256'(3));
        chk("fl3_base0", 256'(base_log[g0[5:0]]),     256'(32'h00));
        chk("fl3_base1", 256'(base_log[6'(g0 + 1)]),  256'(32'h20));
        chk("fl3_base2", 256'(base_log[6'(g0 + 2)]),  256'(32'h40));
        chk("fl3_pulses",256'(flush_n - f0),          256'(1));
        chk("fl3_after", 256'(flush_at_done),         256'(d0 + 3));
        chk_counters("fl3");

        // Repeated requests during a write merge into one pulse
        g0 = go_n; f0 = flush_n;
        push_upd(32'd4, 32'h404);
        flush_req = 1'b1;
        repeat (2) @(negedge clk);
        flush_req = 1'b0;
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        wait_idle(200);
        exp_wr++;
        chk("merge_go",     256'(go_n - g0),    256'(1));
        chk("merge_pulses", 256'(flush_n - f0), 256'(1));

        // Idle flush with an empty FIFO
        f0 = flush_n;
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        wait_idle(50);
        chk("idle_flush", 256'(flush_n - f0), 256'(1));

        // Master buffer full held for 10 cycles in PUSH
        buf_full = 1'b1;
        p0 = push_n;
        push_upd(32'd5, 32'h5A5A0005);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = bus.control_go;
        end
        chk("full_go_seen", 256'(seen), 256'(1));
        bad = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.user_write_buffer) bad = 1'b1;
        end
        chk("full_held", 256'(bad), 256'(0));
        buf_full = 1'b0;
        @(negedge clk);
        chk("full_push_now",  256'(bus.user_write_buffer), 256'(1));
        @(negedge clk);
        chk("full_push_once", 256'(bus.user_write_buffer), 256'(0));
        wait_idle(100);
        exp_wr++;
        chk("full_push_n", 256'(push_n - p0), 256'(1));
        chk("full_data",   last_data, {192'b0, 32'h5A5A0005, 32'd5});
        chk_counters("full");

        // Reset while waiting on control_done with a flush pending
        push_upd(32'd6, 32'h66);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = bus.user_write_buffer;
        end
        chk("rst_push_seen", 256'(seen), 256'(1));
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_async");
        exp_wr = 0;
        exp_drop = 0;
        repeat (2) @(negedge clk);
        f0 = flush_n;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_no_flush", 256'(flush_n - f0), 256'(0));
        g0 = go_n;
        push_upd(32'd2, 32'h2222ABCD);
        wait_idle(100);
        exp_wr++;
        chk("rst_go",   256'(go_n - g0),          256'(1));
        chk("rst_base", 256'(base_log[g0[5:0]]),  256'(32'h40));
        chk("rst_data", last_data, {192'b0, 32'h2222ABCD, 32'd2});
        chk_counters("rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
